game_ctrl_fsm: RTL and testbench
================================

GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_MOLES, default 2, meaning number of simultaneous mole channels (1..8).
REQ-002 SHALL have parameter NUM_STAGES, default 4, meaning stages per game; last stage index is NUM_STAGES-1.
REQ-003 SHALL have parameter COMBO_LEN, default 5, meaning consecutive hits per bonus award (2..15).
REQ-004 SHALL have ports:
- clk_1mhz  in  1  sole clock
- rst  in  1  synchronous active-high reset
- gsm_state  in  3  001 ready, 010 playing, 011 game over, 100 stage clear, 101 game clear
- gsm_stage  in  2  current stage
- gsm_lives  in  2  remaining lives
- gsm_base_score  in  7  remaining stage quota
- gsm_timer  in  7  countdown value
- gsm_timer_running  in  1  timer active
- gsm_sec_posedge  in  1  per-second strobe
- snd_playing  in  1  sound busy
- btn_pressed  in  1  key-held level
- btn_value  in  4  key code; 1..8 holes, 10 start, 11 pause
- mole_pos  in  4*NUM_MOLES  channel k at bits [4k+3:4k]; 0 = no mole
- gsm_trig  out  1  one-cycle command strobe
- gsm_flag  out  4  command code, valid while gsm_trig=1
- snd_trig  out  1  one-cycle sound strobe
- snd_mode  out  3  sound code
- hit_mask  out  NUM_MOLES  channels matched by last hit
- combo  out  4  current consecutive-hit count
- paused  out  1  play suspended

Function
REQ-005 SHALL pass btn_pressed, gsm_sec_posedge, gsm_timer_running through 2-flop synchronisers; press = sync 01, sec tick = 01, timer expiry = 10.
REQ-006 SHALL drive gsm_trig and snd_trig as single-cycle pulses; both deassert every cycle not issuing a command.
REQ-007 SHALL use gsm_flag codes: 0001 score+1, 0010 life-1, 0011 combo bonus, 0101 timer resume, 0110 timer pause, 1000 to ready, 1010 to playing, 1100 stage clear, 1101 game over, 1110 game clear, 1111 reset to ready.
REQ-008 SHALL use snd_mode codes: 001 countdown, 010 start beep, 011 hit, 100 miss, 101 stage clear, 110 game over, 111 game clear; a sound is triggered only when snd_playing=0.
REQ-009 Ready: start press issues 0101 and sets armed; while armed, each sec tick triggers 010 if gsm_timer=0 else 001; timer expiry while armed issues 1010.
REQ-010 Playing, not paused, lives>0: press with code 1..8 is a hit if any channel equals code; hit issues 0001, snd 011, combo+1, hit_mask = all matching channels; else miss issues 0010, snd 100, combo=0, hit_mask=0.
REQ-011 Combo reaching COMBO_LEN SHALL issue 0011 exactly one cycle after the 0001 pulse and reset combo to 0; a press arriving that cycle is dropped.
REQ-012 Playing: pause press toggles paused; entering issues 0110, leaving issues 0101; hole presses while paused are ignored with no pulse.
REQ-013 Playing end (timer expiry or lives=0): issue 1101 if base_score>0, else 1100 if stage<NUM_STAGES-1, else 1110; issued exactly once per stage; expiry and hit in same cycle: end flag wins, hit dropped.
REQ-014 Game over / game clear: trigger 110/111 once after snd_playing=0; start press issues 1111.
REQ-015 Stage clear: trigger 101 once; after snd_playing falls, issue 1000 once.
REQ-016 Any gsm_state change SHALL clear armed, paused, combo, one-shot sound/end latches and any pending bonus.
REQ-017 Codes 0, 9, 12..15 and presses in states not listed SHALL be ignored.

Reset
REQ-018 With rst=1 at a clk_1mhz edge, all outputs SHALL be 0 and all synchronisers, latches and combo cleared next cycle; rst mid-play cancels pending bonus.

Verification
REQ-019 Ready, start press, timer 3->0 ticking: flag 0101; snd 001,001,001 then 010; on running fall flag 1010.
REQ-020 Playing, mole_pos={5,5}, press 5: single 0001 pulse, snd 011, hit_mask=2'b11, combo=1; press 3: 0010, snd 100, combo=0.
REQ-021 COMBO_LEN=5, five hits: fifth 0001 followed next cycle by 0011; combo=0 after.
REQ-022 Playing, press 11: 0110, paused=1; press 5 on mole: no pulse; press 11: 0101, paused=0.
REQ-023 Stage=NUM_STAGES-1, base_score=0, timer expiry coincident with hit press: only 1110, no 0001.
REQ-024 Stage clear with snd_playing low: snd 101 once; after snd_playing 1->0, flag 1000 once.

Source files
------------

// File: rtl/game_ctrl_fsm.sv
`timescale 1ns/1ps
// game_ctrl_fsm
// Gameplay controller for a whack-a-mole game. It turns key presses, the
// per-second strobe and timer status into command pulses for the game state
// machine (gsm_*) and sound requests (snd_*). It also tracks the combo,
// pause and last-hit mask. The game phase itself is owned by the external
// state machine. This block follows it and restarts its own bookkeeping
// whenever that phase changes.
module game_ctrl_fsm #(
    parameter int NUM_MOLES  = 2,
    parameter int NUM_STAGES = 4,
    parameter int COMBO_LEN  = 5
) (
    input  logic                   clk_1mhz,
    input  logic                   rst,
    input  logic [2:0]             gsm_state,
    input  logic [1:0]             gsm_stage,
    input  logic [1:0]             gsm_lives,
    input  logic [6:0]             gsm_base_score,
    input  logic [6:0]             gsm_timer,
    input  logic                   gsm_timer_running,
    input  logic                   gsm_sec_posedge,
    input  logic                   snd_playing,
    input  logic                   btn_pressed,
    input  logic [3:0]             btn_value,
    input  logic [4*NUM_MOLES-1:0] mole_pos,
    output logic                   gsm_trig,
    output logic [3:0]             gsm_flag,
    output logic                   snd_trig,
    output logic [2:0]             snd_mode,
    output logic [NUM_MOLES-1:0]   hit_mask,
    output logic [3:0]             combo,
    output logic                   paused
);

    localparam logic [3:0] KEY_START  = 4'd10;
    localparam logic [3:0] KEY_PAUSE  = 4'd11;

    localparam logic [3:0] CMD_SCORE  = 4'b0001;
    localparam logic [3:0] CMD_LIFE   = 4'b0010;
    localparam logic [3:0] CMD_BONUS  = 4'b0011;
    localparam logic [3:0] CMD_RESUME = 4'b0101;
    localparam logic [3:0] CMD_PAUSE  = 4'b0110;
    localparam logic [3:0] CMD_READY  = 4'b1000;
    localparam logic [3:0] CMD_PLAY   = 4'b1010;
    localparam logic [3:0] CMD_SCLR   = 4'b1100;
    localparam logic [3:0] CMD_OVER   = 4'b1101;
    localparam logic [3:0] CMD_GCLR   = 4'b1110;
    localparam logic [3:0] CMD_RESET  = 4'b1111;

    localparam logic [2:0] SND_COUNT  = 3'b001;
    localparam logic [2:0] SND_START  = 3'b010;
    localparam logic [2:0] SND_HIT    = 3'b011;
    localparam logic [2:0] SND_MISS   = 3'b100;
    localparam logic [2:0] SND_SCLR   = 3'b101;
    localparam logic [2:0] SND_OVER   = 3'b110;
    localparam logic [2:0] SND_GCLR   = 3'b111;

    localparam logic [3:0]  COMBO_TOP  = 4'(COMBO_LEN);
    localparam logic [31:0] LAST_STAGE = 32'(NUM_STAGES - 1);

    // Local view of the external game phase; the encoding mirrors gsm_state.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'b000,
        PH_READY = 3'b001,
        PH_PLAY  = 3'b010,
        PH_OVER  = 3'b011,
        PH_SCLR  = 3'b100,
        PH_GCLR  = 3'b101
    } phase_t;

    phase_t               state_q, state_d;

    logic [1:0]           btn_sync, sec_sync, run_sync;
    logic                 press, sec_tick, run_expiry;
    logic [NUM_MOLES-1:0] match;
    logic                 is_hole, end_req;
    logic [3:0]           end_code;

    logic                 armed_q, armed_d;
    logic                 paused_q, paused_d;
    logic [3:0]           combo_q, combo_d;
    logic                 bonus_q, bonus_d;
    logic                 snd_done_q, snd_done_d;
    logic                 end_done_q, end_done_d;
    logic                 end_pend_q, end_pend_d;
    logic                 ack_done_q, ack_done_d;
    logic                 snd_prev_q, snd_prev_d;
    logic [NUM_MOLES-1:0] hit_mask_q, hit_mask_d;
    logic                 gsm_trig_q, gsm_trig_d;
    logic [3:0]           gsm_flag_q, gsm_flag_d;
    logic                 snd_trig_q, snd_trig_d;
    logic [2:0]           snd_mode_q, snd_mode_d;

    // Two-flop synchronisers; bit 1 is the older sample.
    always_ff @(posedge clk_1mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            btn_sync <= 2'b00;
            sec_sync <= 2'b00;
            run_sync <= 2'b00;
        end else begin
            btn_sync <= {btn_sync[0], btn_pressed};
            sec_sync <= {sec_sync[0], gsm_sec_posedge};
            run_sync <= {run_sync[0], gsm_timer_running};
        end
    end

    assign press      = (btn_sync == 2'b01);
    assign sec_tick   = (sec_sync == 2'b01);
    assign run_expiry = (run_sync == 2'b10);
    assign is_hole    = (btn_value >= 4'd1) && (btn_value <= 4'd8);

    // Flag every mole channel whose position equals the pressed key.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_MOLES; k++) begin
            match[k] = (mole_pos[4*k +: 4] == btn_value);
        end
    end

    // Stage outcome: quota left means game over, otherwise advance or finish.
    always_comb begin
        if (gsm_base_score != 7'd0) begin
            end_code = CMD_OVER;
        end else if ({30'd0, gsm_stage} < LAST_STAGE) begin
            end_code = CMD_SCLR;
        end else begin
            end_code = CMD_GCLR;
        end
    end

    // Phase register.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase follows the external state; unknown codes park in idle.
    always_comb begin
        case (gsm_state)
            3'b001:  state_d = PH_READY;
            3'b010:  state_d = PH_PLAY;
            3'b011:  state_d = PH_OVER;
            3'b100:  state_d = PH_SCLR;
            3'b101:  state_d = PH_GCLR;
            default: state_d = PH_IDLE;
        endcase
    end

    // Per-phase command decisions and next values of all bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        armed_d    = armed_q;
        paused_d   = paused_q;
        combo_d    = combo_q;
        bonus_d    = bonus_q;
        snd_done_d = snd_done_q;
        end_done_d = end_done_q;
        end_pend_d = end_pend_q;
        ack_done_d = ack_done_q;
        hit_mask_d = hit_mask_q;
        snd_prev_d = snd_playing;
        gsm_trig_d = 1'b0;
        gsm_flag_d = 4'b0000;
        snd_trig_d = 1'b0;
        snd_mode_d = 3'b000;
        end_req    = 1'b0;

        if (state_d != state_q) begin
            // A phase change restarts every one-shot and cancels pending work.
            armed_d    = 1'b0;
            paused_d   = 1'b0;
            combo_d    = 4'd0;
            bonus_d    = 1'b0;
            snd_done_d = 1'b0;
            end_done_d = 1'b0;
            end_pend_d = 1'b0;
            ack_done_d = 1'b0;
        end else begin
            case (state_q)
                PH_READY: begin
                    if (armed_q && sec_tick && !snd_playing) begin
                        snd_trig_d = 1'b1;
                        snd_mode_d = (gsm_timer == 7'd0) ? SND_START : SND_COUNT;
                    end
                    if (armed_q && run_expiry) begin
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = CMD_PLAY;
                    end else if (press && btn_value == KEY_START) begin
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = CMD_RESUME;
                        armed_d    = 1'b1;
                    end
                end

                PH_PLAY: begin
                    end_req = !end_done_q && (run_expiry || gsm_lives == 2'd0 || end_pend_q);
                    if (bonus_q) begin
                        // The bonus owns this cycle; a stage end waits one cycle.
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = CMD_BONUS;
                        combo_d    = 4'd0;
                        bonus_d    = 1'b0;
                        if (end_req) begin
                            end_pend_d = 1'b1;
                        end
                    end else if (end_req) begin
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = end_code;
                        end_done_d = 1'b1;
                        end_pend_d = 1'b0;
                    end else if (press && !end_done_q) begin
                        if (btn_value == KEY_PAUSE) begin
                            paused_d   = !paused_q;
                            gsm_trig_d = 1'b1;
                            gsm_flag_d = paused_q ? CMD_RESUME : CMD_PAUSE;
                        end else if (is_hole && !paused_q && gsm_lives != 2'd0) begin
                            gsm_trig_d = 1'b1;
                            snd_trig_d = !snd_playing;
                            if (|match) begin
                                gsm_flag_d = CMD_SCORE;
                                snd_mode_d = snd_playing ? 3'b000 : SND_HIT;
                                hit_mask_d = match;
                                combo_d    = combo_q + 4'd1;
                                bonus_d    = (combo_q + 4'd1 == COMBO_TOP);
                            end else begin
                                gsm_flag_d = CMD_LIFE;
                                snd_mode_d = snd_playing ? 3'b000 : SND_MISS;
                                hit_mask_d = '0;
                                combo_d    = 4'd0;
                            end
                        end
                    end
                end

                PH_OVER, PH_GCLR: begin
                    if (!snd_done_q && !snd_playing) begin
                        snd_trig_d = 1'b1;
                        snd_mode_d = (state_q == PH_OVER) ? SND_OVER : SND_GCLR;
                        snd_done_d = 1'b1;
                    end
                    if (press && btn_value == KEY_START) begin
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = CMD_RESET;
                    end
                end

                PH_SCLR: begin
                    if (!snd_done_q && !snd_playing) begin
                        snd_trig_d = 1'b1;
                        snd_mode_d = SND_SCLR;
                        snd_done_d = 1'b1;
                    end else if (snd_done_q && !ack_done_q && snd_prev_q && !snd_playing) begin
                        gsm_trig_d = 1'b1;
                        gsm_flag_d = CMD_READY;
                        ack_done_d = 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // Bookkeeping and output registers.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            armed_q    <= 1'b0;
            paused_q   <= 1'b0;
            combo_q    <= 4'd0;
            bonus_q    <= 1'b0;
            snd_done_q <= 1'b0;
            end_done_q <= 1'b0;
            end_pend_q <= 1'b0;
            ack_done_q <= 1'b0;
            snd_prev_q <= 1'b0;
            hit_mask_q <= '0;
            gsm_trig_q <= 1'b0;
            gsm_flag_q <= 4'b0000;
            snd_trig_q <= 1'b0;
            snd_mode_q <= 3'b000;
        end else begin
            armed_q    <= armed_d;
            paused_q   <= paused_d;
            combo_q    <= combo_d;
            bonus_q    <= bonus_d;
            snd_done_q <= snd_done_d;
            end_done_q <= end_done_d;
            end_pend_q <= end_pend_d;
            ack_done_q <= ack_done_d;
            snd_prev_q <= snd_prev_d;
            hit_mask_q <= hit_mask_d;
            gsm_trig_q <= gsm_trig_d;
            gsm_flag_q <= gsm_flag_d;
            snd_trig_q <= snd_trig_d;
            snd_mode_q <= snd_mode_d;
        end
    end

    assign gsm_trig = gsm_trig_q;
    assign gsm_flag = gsm_flag_q;
    assign snd_trig = snd_trig_q;
    assign snd_mode = snd_mode_q;
    assign hit_mask = hit_mask_q;
    assign combo    = combo_q;
    assign paused   = paused_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
`timescale 1ns/1ps
// tb_game_ctrl_fsm
// Directed bench for game_ctrl_fsm. Stimulus tasks drive inputs on the falling
// edge. An event-level model schedules the command and sound pulses each
// stimulus must produce. A monitor then compares both pulse channels on every
// cycle. Level outputs are pinned with literal checks.
module tb_game_ctrl_fsm;

    localparam int NUM_MOLES  = 2;
    localparam int NUM_STAGES = 4;
    localparam int COMBO_LEN  = 5;
    localparam int DEPTH      = 4096;

    localparam int S_READY = 1;
    localparam int S_PLAY  = 2;
    localparam int S_OVER  = 3;
    localparam int S_SCLR  = 4;
    localparam int S_GCLR  = 5;

    logic                   clk_1mhz;
    logic                   rst;
    logic [2:0]             gsm_state;
    logic [1:0]             gsm_stage;
    logic [1:0]             gsm_lives;
    logic [6:0]             gsm_base_score;
    logic [6:0]             gsm_timer;
    logic                   gsm_timer_running;
    logic                   gsm_sec_posedge;
    logic                   snd_playing;
    logic                   btn_pressed;
    logic [3:0]             btn_value;
    logic [4*NUM_MOLES-1:0] mole_pos;
    logic                   gsm_trig;
    logic [3:0]             gsm_flag;
    logic                   snd_trig;
    logic [2:0]             snd_mode;
    logic [NUM_MOLES-1:0]   hit_mask;
    logic [3:0]             combo;
    logic                   paused;

    game_ctrl_fsm #(
        .NUM_MOLES (NUM_MOLES),
        .NUM_STAGES(NUM_STAGES),
        .COMBO_LEN (COMBO_LEN)
    ) dut (
        .clk_1mhz         (clk_1mhz),
        .rst              (rst),
        .gsm_state        (gsm_state),
        .gsm_stage        (gsm_stage),
        .gsm_lives        (gsm_lives),
        .gsm_base_score   (gsm_base_score),
        .gsm_timer        (gsm_timer),
        .gsm_timer_running(gsm_timer_running),
        .gsm_sec_posedge  (gsm_sec_posedge),
        .snd_playing      (snd_playing),
        .btn_pressed      (btn_pressed),
        .btn_value        (btn_value),
        .mole_pos         (mole_pos),
        .gsm_trig         (gsm_trig),
        .gsm_flag         (gsm_flag),
        .snd_trig         (snd_trig),
        .snd_mode         (snd_mode),
        .hit_mask         (hit_mask),
        .combo            (combo),
        .paused           (paused)
    );

    initial clk_1mhz = 1'b0;
    always #500 clk_1mhz = ~clk_1mhz;

    int cyc = 0;
    always @(posedge clk_1mhz) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Expected pulse per cycle: -1 means the channel must stay idle.
    int exp_gsm [DEPTH];
    int exp_snd [DEPTH];

    // Model of the game rules.
    int                   m_state;
    bit                   m_armed, m_paused, m_end_done, m_snd_done, m_ack_done;
    int                   m_combo;
    logic [NUM_MOLES-1:0] m_hit_mask;
    int                   m_moles [NUM_MOLES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: both pulse channels against the schedule, every cycle.
    always @(negedge clk_1mhz) begin
        if (cmp_en && cyc < DEPTH) begin
            check("gsm_pulse", gsm_trig ? {27'd0, 1'b1, gsm_flag} : 32'd0,
                  (exp_gsm[cyc] >= 0) ? 32'(16 + exp_gsm[cyc]) : 32'd0);
            check("snd_pulse", snd_trig ? {28'd0, 1'b1, snd_mode} : 32'd0,
                  (exp_snd[cyc] >= 0) ? 32'(8 + exp_snd[cyc]) : 32'd0);
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1mhz);
    endtask

    function automatic void model_clear();
        m_armed    = 1'b0;
        m_paused   = 1'b0;
        m_combo    = 0;
        m_end_done = 1'b0;
        m_snd_done = 1'b0;
        m_ack_done = 1'b0;
    endfunction

    function automatic int end_code();
        if (gsm_base_score != 7'd0) return 13;
        if (int'(gsm_stage) < NUM_STAGES - 1) return 12;
        return 14;
    endfunction

    function automatic int state_sound(input int s);
        if (s == S_OVER) return 6;
        if (s == S_SCLR) return 5;
        return 7;
    endfunction

    function automatic void model_press(input int code, input int at);
        logic [NUM_MOLES-1:0] mask;
        case (m_state)
            S_READY: if (code == 10) begin
                exp_gsm[at] = 5;
                m_armed     = 1'b1;
            end
            S_PLAY: if (!m_end_done) begin
                if (code == 11) begin
                    m_paused    = !m_paused;
                    exp_gsm[at] = m_paused ? 6 : 5;
                end else if (code >= 1 && code <= 8 && !m_paused && gsm_lives != 2'd0) begin
                    mask = '0;
                    for (int k = 0; k < NUM_MOLES; k++) if (m_moles[k] == code) mask[k] = 1'b1;
                    m_hit_mask = mask;
                    if (mask != '0) begin
                        exp_gsm[at] = 1;
                        exp_snd[at] = 3;
                        m_combo++;
                        if (m_combo == COMBO_LEN) begin
                            exp_gsm[at + 1] = 3;
                            m_combo         = 0;
                        end
                    end else begin
                        exp_gsm[at] = 2;
                        exp_snd[at] = 4;
                        m_combo     = 0;
                    end
                end
            end
            S_OVER, S_GCLR: if (code == 10) exp_gsm[at] = 15;
            default: ;
        endcase
    endfunction

    function automatic void model_expiry(input int at);
        if (m_state == S_READY && m_armed) begin
            exp_gsm[at] = 10;
        end else if (m_state == S_PLAY && !m_end_done) begin
            exp_gsm[at] = end_code();
            m_end_done  = 1'b1;
        end
    endfunction

    task automatic press(input int code);
        btn_value   = 4'(code);
        btn_pressed = 1'b1;
        model_press(code, cyc + 2);
        tick(3);
        btn_pressed = 1'b0;
        tick(3);
    endtask

    task automatic sec_tick(input int tval);
        gsm_timer = 7'(tval);
        tick(1);
        gsm_sec_posedge = 1'b1;
        if (m_state == S_READY && m_armed && !snd_playing) exp_snd[cyc + 2] = (tval == 0) ? 2 : 1;
        tick(1);
        gsm_sec_posedge = 1'b0;
        tick(4);
    endtask

    task automatic timer_rise();
        gsm_timer_running = 1'b1;
        tick(4);
    endtask

    task automatic timer_fall();
        gsm_timer_running = 1'b0;
        model_expiry(cyc + 2);
        tick(5);
    endtask

    task automatic expire_with_press(input int code);
        gsm_timer_running = 1'b0;
        btn_value         = 4'(code);
        btn_pressed       = 1'b1;
        model_expiry(cyc + 2);
        model_press(code, cyc + 2);
        tick(3);
        btn_pressed = 1'b0;
        tick(3);
    endtask

    task automatic set_state(input int s);
        gsm_state = 3'(s);
        m_state   = s;
        model_clear();
        if ((s == S_OVER || s == S_SCLR || s == S_GCLR) && !snd_playing) begin
            exp_snd[cyc + 2] = state_sound(s);
            m_snd_done       = 1'b1;
        end
        tick(5);
    endtask

    task automatic snd_fall();
        snd_playing = 1'b0;
        if ((m_state == S_OVER || m_state == S_SCLR || m_state == S_GCLR) && !m_snd_done) begin
            exp_snd[cyc + 1] = state_sound(m_state);
            m_snd_done       = 1'b1;
        end else if (m_state == S_SCLR && !m_ack_done) begin
            exp_gsm[cyc + 1] = 8;
            m_ack_done       = 1'b1;
        end
        tick(5);
    endtask

    task automatic snd_busy(input int len);
        snd_playing = 1'b1;
        tick(len);
        snd_fall();
    endtask

    task automatic set_moles(input int m1, input int m0);
        mole_pos   = {4'(m1), 4'(m0)};
        m_moles[0] = m0;
        m_moles[1] = m1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gsm_trig"}, 32'(gsm_trig), 32'd0);
        check({tag, "_gsm_flag"}, 32'(gsm_flag), 32'd0);
        check({tag, "_snd_trig"}, 32'(snd_trig), 32'd0);
        check({tag, "_snd_mode"}, 32'(snd_mode), 32'd0);
        check({tag, "_hit_mask"}, 32'(hit_mask), 32'd0);
        check({tag, "_combo"},    32'(combo),    32'd0);
        check({tag, "_paused"},   32'(paused),   32'd0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < DEPTH; i++) begin
            exp_gsm[i] = -1;
            exp_snd[i] = -1;
        end
        rst               = 1'b1;
        gsm_state         = 3'(S_READY);
        m_state           = S_READY;
        gsm_stage         = 2'd0;
        gsm_lives         = 2'd3;
        gsm_base_score    = 7'd10;
        gsm_timer         = 7'd3;
        gsm_timer_running = 1'b0;
        gsm_sec_posedge   = 1'b0;
        snd_playing       = 1'b0;
        btn_pressed       = 1'b0;
        btn_value         = 4'd0;
        set_moles(5, 5);
        model_clear();
        m_hit_mask = '0;

        // Reset state.
        tick(1);
        cmp_en = 1'b1;
        tick(2);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(4);

        // Ready: stray keys and unarmed ticks do nothing, then arm and count down.
        press(11);
        press(5);
        sec_tick(5);
        press(10);
        timer_rise();
        sec_tick(3);
        sec_tick(2);
        sec_tick(1);
        sec_tick(0);
        timer_fall();

        // Playing: hit on both channels, then a miss, then ignored codes.
        set_state(S_PLAY);
        press(5);
        check("hit_mask_both", 32'(hit_mask), 32'd3);
        check("combo_after_hit", 32'(combo), 32'd1);
        press(3);
        check("combo_after_miss", 32'(combo), 32'd0);
        check("hit_mask_after_miss", 32'(hit_mask), 32'd0);
        press(0);
        press(9);
        press(12);
        press(15);

        // Distinct channels; five straight hits earn the bonus.
        set_moles(3, 5);
        press(3);
        check("hit_mask_ch1", 32'(hit_mask), 32'd2);
        press(5);
        check("hit_mask_ch0", 32'(hit_mask), 32'd1);
        press(3);
        press(3);
        check("combo_four", 32'(combo), 32'd4);
        press(5);
        check("combo_after_bonus", 32'(combo), 32'd0);
        check("model_combo_agrees", 32'(combo), 32'(m_combo));

        // Pause toggling; hole presses while paused are silent.
        press(11);
        check("paused_set", 32'(paused), 32'd1);
        press(5);
        check("combo_paused", 32'(combo), 32'd0);
        press(11);
        check("paused_clear", 32'(paused), 32'd0);

        // Losing the last life ends the stage once, with quota left.
        gsm_lives = 2'd0;
        exp_gsm[cyc + 1] = end_code();
        m_end_done = 1'b1;
        tick(8);
        gsm_lives = 2'd3;
        tick(2);

        // Stage clear: one sound, then one ready command after the sound ends.
        set_state(S_SCLR);
        snd_busy(5);
        snd_busy(5);

        // Last stage, quota met: expiry collides with a hit press.
        gsm_stage      = 2'd3;
        gsm_base_score = 7'd0;
        set_state(S_PLAY);
        timer_rise();
        expire_with_press(3);
        check("combo_end_collision", 32'(combo), 32'd0);

        // Game over while sound is busy: sound waits for idle; start resets.
        snd_playing = 1'b1;
        set_state(S_OVER);
        snd_fall();
        snd_busy(3);
        press(10);
        set_state(S_GCLR);
        press(10);

        // Middle stage with quota met ends as a stage clear.
        gsm_stage = 2'd1;
        set_state(S_PLAY);
        timer_rise();
        timer_fall();

        // Reset between the fifth hit and its bonus cancels the bonus.
        gsm_stage      = 2'd0;
        gsm_base_score = 7'd10;
        set_state(S_READY);
        set_state(S_PLAY);
        repeat (4) press(5);
        check("combo_before_reset", 32'(combo), 32'd4);
        btn_value   = 4'd5;
        btn_pressed = 1'b1;
        c = cyc;
        model_press(5, c + 2);
        exp_gsm[c + 3] = -1;
        tick(2);
        rst         = 1'b1;
        btn_pressed = 1'b0;
        model_clear();
        m_hit_mask = '0;
        tick(2);
        check_idle_outputs("midreset");
        rst = 1'b0;
        tick(6);
        check("combo_post_reset", 32'(combo), 32'd0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
